// File: rtl/hs4_rx_sync_pkg.sv
// Shared types for the 4-phase bundled-data receiver: FSM states and default word width.
package hs4_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    RECOVER = 2'd0,
    IDLE    = 2'd1,
    ACK_HI  = 2'd2,
    ACK_LO  = 2'd3
  } state_t;

endpackage

// File: rtl/hs4_rx_sync_if.sv
// Bundle of the pipeline-side req/ack/data channel and the clocked valid/ready output.
interface hs4_rx_sync_if #(
  parameter int DATA_W     = hs4_pkg::DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output req_in, data_in, dout_ready,
    input  ack_out, dout, dout_valid, fifo_count
  );

  modport slave (
    input  req_in, data_in, dout_ready,
    output ack_out, dout, dout_valid, fifo_count
  );

endinterface

// File: rtl/hs4_rx_sync_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; the writer must never push when full.
module sync_fifo
  import hs4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       ready,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              pop;

  assign dout_valid = (count_q != '0);
  assign pop        = dout_valid & ready;
  // Head is forced to zero while empty so the output is defined without resetting storage.
  assign dout       = dout_valid ? mem[rd_ptr] : '0;
  assign count      = count_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hs4_rx_sync.sv
// Clocked receiver for a 4-phase bundled-data channel; acks only words it can store.
module hs4_rx_sync
  import hs4_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hs4_rx_sync_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] req_sync_p;
  logic                   req_s;
  state_t                 state;
  logic                   ack_q;
  logic                   push;
  logic [CNT_W-1:0]       count;

  // Synchronizer resets to 1 so a request held across reset is not taken as a new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_sync_p <= '1;
    else        req_sync_p <= {req_sync_p[SYNC_STAGES-2:0], bus.req_in};
  end

  assign req_s = req_sync_p[SYNC_STAGES-1];
  // data_in is bundled: stable from req rise until ack rise, so it is captured unsynchronized.
  assign push  = (state == IDLE) && req_s && (count < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RECOVER;
      ack_q <= 1'b0;
    end else begin
      case (state)
        RECOVER: begin
          ack_q <= 1'b0;
          if (!req_s) state <= IDLE;
        end
        IDLE: begin
          ack_q <= push;
          if (push) state <= ACK_HI;
        end
        ACK_HI: begin
          if (!req_s) begin
            state <= ACK_LO;
            ack_q <= 1'b0;
          end
        end
        ACK_LO: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          state <= RECOVER;
        end
      endcase
    end
  end

  assign bus.ack_out    = ack_q;
  assign bus.fifo_count = count;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (bus.data_in),
    .ready      (bus.dout_ready),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .count      (count)
  );

endmodule

// File: tb/tb_hs4_rx_sync.sv
// Directed bench for hs4_rx_sync: reset, single word, backpressure, streaming, reset abort, async phase.
module tb_hs4_rx_sync;
  import hs4_pkg::*;

  localparam int DW    = 3;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  hs4_rx_sync_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  hs4_rx_sync #(.DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.ack_out === lvl) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic poll_ack(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.ack_out === lvl) begin
        ok = 1'b1;
        break;
      end
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] w, output bit ok);
    bit a, b;
    bus.data_in = w;
    bus.req_in  = 1'b1;
    wait_ack(1'b1, 40, a);
    bus.req_in  = 1'b0;
    wait_ack(1'b0, 40, b);
    ok = a & b;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req_in     = 1'b1;
    bus.data_in    = '0;
    bus.dout_ready = 1'b0;
    tick(3);
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b exp=0", bus.ack_out); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.dout_valid); end
    total++; if (bus.dout !== 3'd0) begin bad++; $display("FAIL reset_dout got=%0d exp=0", bus.dout); end
    rst_n = 1'b1;
    tick(10);
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL held_req_ack got=%0b exp=0", bus.ack_out); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL held_req_count got=%0d exp=0", bus.fifo_count); end
    bus.req_in = 1'b0;
    tick(2);
    total++; if (dut.state !== RECOVER) begin bad++; $display("FAIL recover_hold got=%0d exp=%0d", dut.state, RECOVER); end
    tick(1);
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL recover_idle got=%0d exp=%0d", dut.state, IDLE); end
  endtask

  task automatic test_single();
    bus.data_in = 3'b001;
    bus.req_in  = 1'b1;
    tick(2);
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL single_ack_early got=%0b exp=0", bus.ack_out); end
    tick(1);
    total++; if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL single_ack got=%0b exp=1", bus.ack_out); end
    total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.fifo_count); end
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 3'b001) begin bad++; $display("FAIL single_dout got=%0d exp=1", bus.dout); end
    bus.req_in = 1'b0;
    tick(2);
    total++; if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL single_ack_hold got=%0b exp=1", bus.ack_out); end
    tick(1);
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL single_ack_fall got=%0b exp=0", bus.ack_out); end
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", bus.fifo_count); end
    total++; if (bus.dout !== 3'd0) begin bad++; $display("FAIL single_pop_dout got=%0d exp=0", bus.dout); end
    tick(2);
  endtask

  task automatic test_stream();
    bit ok;
    int acked = 0;
    bus.dout_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      send(3'(w), ok);
      if (ok) acked++;
    end
    total++; if (acked !== 4) begin bad++; $display("FAIL stream_acked got=%0d exp=4", acked); end
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL stream_full got=%0d exp=4", bus.fifo_count); end
    bus.data_in = 3'b101;
    bus.req_in  = 1'b1;
    tick(8);
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL stream_stall_ack got=%0b exp=0", bus.ack_out); end
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL stream_stall_count got=%0d exp=4", bus.fifo_count); end
    total++; if (bus.dout !== 3'b001) begin bad++; $display("FAIL stream_head got=%0d exp=1", bus.dout); end
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("FAIL stream_pop_count got=%0d exp=3", bus.fifo_count); end
    wait_ack(1'b1, 5, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stream_fifth_ack got=%0b exp=1", ok); end
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL stream_refill got=%0d exp=4", bus.fifo_count); end
    bus.req_in = 1'b0;
    wait_ack(1'b0, 10, ok);
    bus.dout_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      total++; if (bus.dout !== 3'(k)) begin bad++; $display("FAIL stream_order got=%0d exp=%0d", bus.dout, k); end
      tick(1);
    end
    bus.dout_ready = 1'b0;
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%0b exp=0", bus.dout_valid); end
    tick(2);
  endtask

  task automatic test_full_stream();
    bit ok;
    int timeouts = 0;
    int got      = 0;
    int maxc     = 0;
    bus.dout_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(3'((i * 5 + 3) % 8));
      send(3'((i * 5 + 3) % 8), ok);
      if (!ok) timeouts++;
    end
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL full_prefill got=%0d exp=4", bus.fifo_count); end
    fork
      begin
        bit sok;
        for (int i = 4; i < 24; i++) begin
          exp_q.push_back(3'((i * 5 + 3) % 8));
          send(3'((i * 5 + 3) % 8), sok);
          if (!sok) timeouts++;
        end
      end
      begin
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 1500 && got < 24; c++) begin
          if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
          if (bus.dout_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL full_extra_word got=%0d exp=none", bus.dout);
            end else if (bus.dout !== exp_q[0]) begin
              bad++; $display("FAIL full_data got=%0d exp=%0d", bus.dout, exp_q[0]);
              void'(exp_q.pop_front());
            end else begin
              void'(exp_q.pop_front());
            end
            got++;
          end
          tick(1);
        end
        bus.dout_ready = 1'b0;
      end
    join
    total++; if (timeouts !== 0) begin bad++; $display("FAIL full_timeouts got=%0d exp=0", timeouts); end
    total++; if (got !== 24) begin bad++; $display("FAIL full_words got=%0d exp=24", got); end
    total++; if (maxc > 4) begin bad++; $display("FAIL full_maxcount got=%0d exp<=4", maxc); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL full_left got=%0d exp=0", exp_q.size()); end
    tick(2);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.dout_ready = 1'b0;
    bus.data_in    = 3'b110;
    bus.req_in     = 1'b1;
    wait_ack(1'b1, 10, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_ack got=%0b exp=1", ok); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL mid_ack_drop got=%0b exp=0", bus.ack_out); end
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", bus.dout_valid); end
    tick(2);
    rst_n = 1'b1;
    tick(10);
    total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL mid_held_ack got=%0b exp=0", bus.ack_out); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL mid_held_count got=%0d exp=0", bus.fifo_count); end
    bus.req_in = 1'b0;
    tick(4);
    bus.data_in = 3'b111;
    bus.req_in  = 1'b1;
    wait_ack(1'b1, 10, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_new_ack got=%0b exp=1", ok); end
    total++; if (bus.dout !== 3'b111) begin bad++; $display("FAIL mid_new_dout got=%0d exp=7", bus.dout); end
    total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL mid_new_count got=%0d exp=1", bus.fifo_count); end
    bus.req_in = 1'b0;
    wait_ack(1'b0, 10, ok);
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_async();
    int            dly [8] = '{6, 2, 1, 1, 3, 7, 4, 9};
    logic [DW-1:0] words [4] = '{3'd2, 3'd7, 3'd4, 3'd1};
    bit a, b;
    int done = 0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #(dly[2*i]);
      bus.data_in = words[i];
      bus.req_in  = 1'b1;
      poll_ack(1'b1, a);
      #(dly[2*i+1]);
      bus.req_in = 1'b0;
      poll_ack(1'b0, b);
      if (a && b) done++;
    end
    total++; if (done !== 4) begin bad++; $display("FAIL async_handshakes got=%0d exp=4", done); end
    tick(2);
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL async_count got=%0d exp=4", bus.fifo_count); end
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dout !== words[i]) begin bad++; $display("FAIL async_data got=%0d exp=%0d", bus.dout, words[i]); end
      tick(1);
    end
    bus.dout_ready = 1'b0;
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL async_drained got=%0b exp=0", bus.dout_valid); end
  endtask

  initial begin
    bus.req_in     = 1'b0;
    bus.data_in    = '0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_full_stream();
    test_reset_mid();
    test_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
